// File: rtl/prim_generic_count_dual.sv
// Redundantly encoded saturating up/down counter: an up-counter and its complement
// down-counter are kept in separate registers, and any disagreement raises a sticky error.

module prim_generic_buf #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in_i;
endmodule

module prim_generic_count_dual #(
  parameter int          Width      = 8,
  parameter int unsigned ResetValue = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_next_o,
  output logic             err_o
);

  localparam logic [Width-1:0] Max       = '1;
  localparam logic [Width-1:0] ResetUp   = Width'(ResetValue);
  localparam logic [Width-1:0] ResetDown = Max - ResetUp;

  logic [Width-1:0] up_q, up_d, up_buf;
  logic [Width-1:0] down_q, down_d, down_buf;
  logic             err_q;
  logic             mismatch;

  logic [Width:0]   up_sum, up_dif, down_sum, down_dif;
  logic [Width-1:0] up_inc, up_dec, down_inc, down_dec;
  logic             do_incr, do_decr;

  // Each copy has its own adders and saturation; down_q never looks at up_q.
  assign up_sum   = {1'b0, up_q} + {1'b0, step_i};
  assign up_dif   = {1'b0, up_q} - {1'b0, step_i};
  assign up_inc   = up_sum[Width] ? Max : up_sum[Width-1:0];
  assign up_dec   = up_dif[Width] ? '0  : up_dif[Width-1:0];

  assign down_sum = {1'b0, down_q} + {1'b0, step_i};
  assign down_dif = {1'b0, down_q} - {1'b0, step_i};
  assign down_inc = down_sum[Width] ? Max : down_sum[Width-1:0];
  assign down_dec = down_dif[Width] ? '0  : down_dif[Width-1:0];

  assign do_incr  = incr_en_i & ~decr_en_i;
  assign do_decr  = decr_en_i & ~incr_en_i;

  // NOTE: every path assigns up_d/down_d first, so no latch can be inferred.
  always_comb begin
    up_d   = up_q;
    down_d = down_q;
    if (clr_i) begin
      up_d   = ResetUp;
      down_d = ResetDown;
    end else if (set_i) begin
      up_d   = set_cnt_i;
      down_d = Max - set_cnt_i;
    end else if (do_incr) begin
      up_d   = up_inc;
      down_d = down_dec;
    end else if (do_decr) begin
      up_d   = up_dec;
      down_d = down_inc;
    end
  end

  prim_generic_buf #(.Width(Width)) u_up_buf (
    .in_i  (up_d),
    .out_o (up_buf)
  );

  prim_generic_buf #(.Width(Width)) u_down_buf (
    .in_i  (down_d),
    .out_o (down_buf)
  );

  assign mismatch = ({1'b0, up_q} + {1'b0, down_q}) != {1'b0, Max};

  // NOTE: non-blocking assignments keep all three registers sampling the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_q   <= ResetUp;
      down_q <= ResetDown;
      err_q  <= 1'b0;
    end else begin
      up_q   <= up_buf;
      down_q <= down_buf;
      err_q  <= err_q | mismatch;
    end
  end

  assign cnt_o      = up_q;
  assign cnt_next_o = up_buf;
  assign err_o      = mismatch | err_q;

endmodule
